// File: rtl/trace_capture_buffer.sv
// Commit-trace capture buffer: PC-triggered circular record store, drained oldest-first.
// Optional cycle stamping is enabled by defining TRACE_CYCLE_STAMP_EN.
module trace_capture_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_arm,
  input  logic                       i_mode,
  input  logic                       i_trigEn,
  input  logic [XLEN-1:0]            i_trigPC,
  input  logic                       i_stop,
  input  logic                       i_commitValid,
  input  logic [XLEN-1:0]            i_PC,
  input  logic [4:0]                 i_rdAddr,
  input  logic [XLEN-1:0]            i_rdData,
  output logic                       o_rdValid,
  input  logic                       i_rdReady,
  output logic [XLEN-1:0]            o_recPC,
  output logic [4:0]                 o_recRdAddr,
  output logic [XLEN-1:0]            o_recRdData,
  output logic [CNT_W-1:0]           o_recCycle,
  output logic [1:0]                 o_state,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CAPT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            r_mode;
  logic            w_rdValid;
  logic            w_match;
  logic            w_full;
  logic            w_we;
  logic            w_ovw;
  logic            w_pop;

  logic [XLEN-1:0] r_memPC   [DEPTH];
  logic [4:0]      r_memRd   [DEPTH];
  logic [XLEN-1:0] r_memData [DEPTH];

  assign w_match = (i_PC == i_trigPC);
  assign w_full  = (r_count == CW'(DEPTH));

  // A stop in ARMED wins over a same-cycle trigger match.
  assign w_we = !i_arm && i_commitValid &&
                ((r_state == S_CAPT) ||
                 (r_state == S_ARMED && w_match && !i_stop));
  assign w_ovw = w_we && r_mode && w_full;
  assign w_pop = !i_arm && w_rdValid && i_rdReady;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_arm) begin
      w_next = i_trigEn ? S_ARMED : S_CAPT;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (i_stop)    w_next = S_DONE;
          else if (w_we) w_next = S_CAPT;
        end
        S_CAPT: begin
          if (i_stop)
            w_next = S_DONE;
          else if (w_we && !r_mode && r_count == CW'(DEPTH - 1))
            w_next = S_DONE;
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_rdValid = (r_state == S_DONE) && (r_count != '0);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_mode     <= 1'b0;
    end else if (i_arm) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_mode     <= i_mode;
    end else begin
      if (w_we) begin
        r_wptr <= r_wptr + AW'(1);
        if (w_ovw) begin
          r_rptr     <= r_rptr + AW'(1);
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + AW'(1);
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_we) begin
      r_memPC[r_wptr]   <= i_PC;
      r_memRd[r_wptr]   <= i_rdAddr;
      r_memData[r_wptr] <= i_rdData;
    end
  end

`ifdef TRACE_CYCLE_STAMP_EN
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_memCyc [DEPTH];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_cycle <= '0;
    else         r_cycle <= r_cycle + CNT_W'(1);
  end

  always_ff @(posedge i_clock) begin
    if (w_we) r_memCyc[r_wptr] <= r_cycle;
  end

  assign o_recCycle = w_rdValid ? r_memCyc[r_rptr] : '0;
`else
  assign o_recCycle = '0;
`endif

  // Record outputs are gated so they read zero whenever nothing is offered.
  assign o_recPC     = w_rdValid ? r_memPC[r_rptr]   : '0;
  assign o_recRdAddr = w_rdValid ? r_memRd[r_rptr]   : '0;
  assign o_recRdData = w_rdValid ? r_memData[r_rptr] : '0;
  assign o_rdValid   = w_rdValid;
  assign o_state     = r_state;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Randomized + directed bench for trace_capture_buffer against a queue-based model.
// Expected stamps follow TRACE_CYCLE_STAMP_EN when the bench is built with it.
module tb_trace_capture_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             arm, mode, ten, stop, cv, rdy;
  logic [XLEN-1:0]  trigpc, pc, rdd;
  logic [4:0]       rda;
  logic             o_rdValid, o_overflow;
  logic [XLEN-1:0]  o_recPC, o_recRdData;
  logic [4:0]       o_recRdAddr;
  logic [CNT_W-1:0] o_recCycle;
  logic [1:0]       o_state;
  logic [2:0]       o_count;

  trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clock(clk), .i_reset(rst), .i_arm(arm), .i_mode(mode),
    .i_trigEn(ten), .i_trigPC(trigpc), .i_stop(stop),
    .i_commitValid(cv), .i_PC(pc), .i_rdAddr(rda), .i_rdData(rdd),
    .o_rdValid(o_rdValid), .i_rdReady(rdy), .o_recPC(o_recPC),
    .o_recRdAddr(o_recRdAddr), .o_recRdData(o_recRdData),
    .o_recCycle(o_recCycle), .o_state(o_state), .o_count(o_count),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [31:0] cyc;
  } rec_t;

  rec_t        q[$];
  int          ms;
  bit          mmode, movf;
  int unsigned mcyc;
  int          nchk = 0;
  int          nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stamp_of(input logic [31:0] c);
`ifdef TRACE_CYCLE_STAMP_EN
    return c;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    ms = 0; mmode = 0; movf = 0; mcyc = 0;
  endtask

  task automatic push_rec(input int unsigned st);
    rec_t r;
    r.pc = pc; r.rd = rda; r.d = rdd; r.cyc = st;
    if (mmode && q.size() == DEPTH) begin
      void'(q.pop_front());
      movf = 1;
    end
    q.push_back(r);
  endtask

  task automatic model_edge();
    int unsigned st;
    st = mcyc;
    mcyc++;
    if (arm) begin
      q.delete(); movf = 0; mmode = mode;
      ms = ten ? 1 : 2;
    end else begin
      case (ms)
        1: if (stop) ms = 3;
           else if (cv && pc == trigpc) begin push_rec(st); ms = 2; end
        2: begin
          if (cv) push_rec(st);
          if (stop || (!mmode && q.size() == DEPTH)) ms = 3;
        end
        3: if (rdy && q.size() > 0) void'(q.pop_front());
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    bit v;
    v = (ms == 3) && (q.size() > 0);
    chk("state", o_state, ms);
    chk("count", o_count, q.size());
    chk("ovf", o_overflow, movf);
    chk("valid", o_rdValid, v);
    if (v) begin
      chk("recPC", o_recPC, q[0].pc);
      chk("recRd", o_recRdAddr, q[0].rd);
      chk("recData", o_recRdData, q[0].d);
      chk("recCyc", o_recCycle, stamp_of(q[0].cyc));
    end
  endtask

  task automatic step(input bit a, input bit m, input bit t, input bit s,
                      input bit c, input logic [31:0] p, input bit r);
    arm = a; mode = m; ten = t; stop = s; cv = c; pc = p; rdy = r;
    rda = 5'($urandom); rdd = $urandom;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, r);
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arm = 0; mode = 0; ten = 0; stop = 0; cv = 0; rdy = 0;
    pc = 0; rda = 0; rdd = 0; trigpc = 0;
    rst = 1;
    model_reset();
    #12;
    chk("rst_state", o_state, 0);
    chk("rst_count", o_count, 0);
    chk("rst_valid", o_rdValid, 0);
    chk("rst_recPC", o_recPC, 0);
    chk("rst_ovf", o_overflow, 0);
    do_reset();

    // stop-when-full, immediate capture
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 32'(i * 4), 0);
    chk("t1_state", o_state, 3);
    chk("t1_count", o_count, 4);
    chk("t1_pc0", o_recPC, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_drain", o_recPC, 32'(i * 4));
      step(0, 0, 0, 0, 0, 0, 1);
    end
    chk("t1_empty", o_rdValid, 0);

    // PC trigger
    trigpc = 32'h100;
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hF8, 0);
    step(0, 0, 0, 0, 1, 32'hFC, 0);
    chk("t2_armed", o_state, 1);
    step(0, 0, 0, 0, 1, 32'h100, 0);
    step(0, 0, 0, 0, 1, 32'h104, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("t2_count", o_count, 2);
    chk("t2_pc0", o_recPC, 32'h100);
    idle(2, 1);

    // ring mode overflow
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 32'(i * 4), 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("t3_count", o_count, 4);
    chk("t3_ovf", o_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", o_recPC, 32'(8 + i * 4));
      step(0, 0, 0, 0, 0, 0, 1);
    end

    // stop with same-cycle commit, gated drain
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h10, 0);
    step(0, 0, 0, 1, 1, 32'h20, 0);
    chk("t4_state", o_state, 3);
    chk("t4_count", o_count, 2);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t4_pc", o_recPC, 32'h20);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t4_hold", o_count, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t4_done", o_count, 0);

    // cycle stamps at counter 5 and 9
    do_reset();
    idle(3, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    step(0, 0, 0, 0, 1, 32'h40, 0);
    idle(3, 0);
    step(0, 0, 0, 0, 1, 32'h44, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("t5_cyc0", o_recCycle, stamp_of(5));
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t5_cyc1", o_recCycle, stamp_of(9));
    step(0, 0, 0, 0, 0, 0, 1);

    // async reset mid-drain
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 32'(i), 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("t6_count", o_count, 3);
    #2;
    rst = 1;
    #1;
    chk("t6_state", o_state, 0);
    chk("t6_cnt0", o_count, 0);
    chk("t6_valid", o_rdValid, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h80, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("t6_rearm", o_recPC, 32'h80);
    idle(1, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      int sel;
      sel = $urandom_range(0, 3);
      p = (sel == 0) ? trigpc : (sel == 1) ? trigpc + 4 : $urandom;
      step($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 29) == 0, 1'($urandom), p, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/trace_capture_buffer.md
# trace_capture_buffer

Parametrised, synthesizable commit-trace capture buffer for the RISC-V core. It records retired-instruction records (PC, rd, rd data, optional cycle stamp) into an on-chip circular buffer. Capture begins on a PC-match trigger or immediately, and ends on full or stop. Records are then drained oldest-first over a valid/ready port. It sits beside the core's writeback stage and replaces console-only logging with a trace that survives into hardware.

## Interface
- XLEN, 32, data/PC width
- DEPTH, 16, record slots; power of 2, ≥ 2
- CNT_W, 32, cycle-stamp width
- i_clock  in  1  clock, all state on rising edge
- i_reset  in  1  reset; one clock; reset is asynchronous and active-high
- i_arm  in  1  single-cycle pulse: clear buffer, start new capture
- i_mode  in  1  sampled on arm: 0 = stop-when-full, 1 = ring (overwrite oldest)
- i_trigEn  in  1  sampled on arm: 1 = wait for PC match, 0 = capture immediately
- i_trigPC  in  XLEN  trigger PC
- i_stop  in  1  end capture
- i_commitValid  in  1  an instruction retires this cycle
- i_PC  in  XLEN  retiring PC
- i_rdAddr  in  5  retiring rd index
- i_rdData  in  XLEN  retiring rd value
- o_rdValid  out  1  record available (DONE only)
- i_rdReady  in  1  consumer accepts record
- o_recPC  out  XLEN  oldest record PC
- o_recRdAddr  out  5  oldest record rd
- o_recRdData  out  XLEN  oldest record rd value
- o_recCycle  out  CNT_W  oldest record cycle stamp
- o_state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
- o_count  out  $clog2(DEPTH)+1  records held
- o_overflow  out  1  ring mode discarded ≥1 record

## Operation
- Reset: state IDLE, count 0, wptr/rptr 0, overflow 0, cycle counter 0, mode/trigEn regs 0; all o_rec* 0; o_rdValid 0.
- Priority per edge: reset > i_arm > i_stop > commit.
- i_arm in any state: clear pointers, count, and overflow; latch i_mode/i_trigEn; go to ARMED (trigEn=1) or CAPTURE (trigEn=0). A commit in the arm cycle is not recorded.
- ARMED: commit with i_PC == i_trigPC → CAPTURE, and that commit is recorded as record 0. Non-matching commits are dropped. i_stop → DONE with count 0.
- CAPTURE, each commit writes {PC, rdAddr, rdData, stamp} at wptr, wptr+1 mod DEPTH:
  - mode 0: count+1; the write making count==DEPTH also moves state to DONE.
  - mode 1, count<DEPTH: count+1.
  - mode 1, full: overwrite oldest, rptr+1 mod DEPTH, count stays DEPTH, overflow←1.
- CAPTURE + i_stop: commit in same cycle is still recorded; next state DONE.
- DONE: o_rdValid = (count>0). Pop on o_rdValid & i_rdReady: rptr+1 mod DEPTH, count−1. Commits and i_stop are ignored. Remains DONE at count 0 until i_arm.
- o_rec* are combinational reads of slot rptr; they are don't-care when o_rdValid=0.
- Cycle counter increments every cycle from reset and wraps modulo 2^CNT_W. The stamp is the counter value before the increment on the write edge.
- In IDLE, commits, i_stop, and i_rdReady have no effect.

## Timing
- Write latency: record visible in slot 1 edge after commit. o_count updates on the same edge.
- Readout: zero-latency valid. A record popped on edge N presents the next record combinationally after N.
- State transitions take effect on the edge of the causing input. o_state is registered.
- Async i_reset assertion mid-capture or mid-drain clears everything immediately. Records are lost.

## Configuration
- TRACE_CYCLE_STAMP_EN defined: cycle counter and per-slot stamp storage present; o_recCycle carries the stamp.
- Undefined: no counter or stamp storage; o_recCycle tied to 0. All other behaviour identical.

## Test plan
- DEPTH=4, mode 0, trigEn 0: arm, commit PCs 0x0,0x4,0x8,0xC → DONE after 4th, count 4. Drain with ready=1 returns 0x0..0xC in order, then o_rdValid=0.
- trigEn 1, trigPC 0x100: commits 0xF8,0xFC,0x100,0x104, stop → 2 records (0x100,0x104), rd data intact.
- DEPTH=4, mode 1: 6 commits 0x0..0x14, stop → count 4, overflow 1, drain yields 0x8,0xC,0x10,0x14.
- Stop and commit 0x20 same cycle in CAPTURE → 0x20 recorded, state DONE. Drain with ready toggling 1,0,1 → pops only on ready-high cycles.
- With TRACE_CYCLE_STAMP_EN: commits at counter 5 and 9 → o_recCycle 5 then 9. Without the macro → o_recCycle 0.
- Async reset asserted mid-drain at count 3 → state 0, count 0, o_rdValid 0 immediately. Re-arm works normally.
